// File: rtl/fix_checksum_scheduler.sv
// fix_checksum_scheduler: arbitrates two checksum producers into one in-order queue for the FIX packet buffer
module fix_checksum_scheduler #(
    parameter int DEPTH = 4,
    parameter int CSUM_WIDTH = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    src0_vld,
    input  logic [CSUM_WIDTH-1:0]   src0_csum,
    output logic                    src0_rdy,
    input  logic                    src1_vld,
    input  logic [CSUM_WIDTH-1:0]   src1_csum,
    output logic                    src1_rdy,
    output logic [CSUM_WIDTH-1:0]   fix_new_checksum,
    output logic                    fix_checksum_vld,
    output logic                    head_src,
    input  logic                    rd_fix,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    err_underflow,
    output logic                    err_overflow
);
    localparam int AW = $clog2(DEPTH);
    logic [CSUM_WIDTH-1:0] csum_mem [DEPTH];
    logic [DEPTH-1:0]      src_mem;
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  last_grant, full, empty, push, pop;
    always_comb begin
        full = occupancy == (AW+1)'(DEPTH);
        empty = occupancy == '0;
        src0_rdy = !reset && !full && src0_vld && (!src1_vld || last_grant);
        src1_rdy = !reset && !full && src1_vld && (!src0_vld || !last_grant);
        push = src0_rdy || src1_rdy;
        pop = rd_fix && !empty;
        fix_checksum_vld = !empty;
        fix_new_checksum = empty ? '0 : csum_mem[rd_ptr];
        head_src = !empty && src_mem[rd_ptr];
    end
    // full is judged on the registered count, so a same-cycle pop never frees a slot early
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occupancy <= '0;
            last_grant <= 1'b1;
            err_underflow <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (push) begin
                csum_mem[wr_ptr] <= src1_rdy ? src1_csum : src0_csum;
                src_mem[wr_ptr] <= src1_rdy;
                wr_ptr <= wr_ptr + 1'b1;
                last_grant <= src1_rdy;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push != pop) occupancy <= push ? occupancy + 1'b1 : occupancy - 1'b1;
            if (rd_fix && empty) err_underflow <= 1'b1;
            if ((src0_vld || src1_vld) && full) err_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fix_checksum_scheduler.sv
// tb_fix_checksum_scheduler: directed scenarios plus randomized traffic against a queue-based model
module tb_fix_checksum_scheduler;
    localparam int DEPTH = 4;
    logic clk = 1'b0, reset = 1'b1;
    logic src0_vld = 1'b0, src1_vld = 1'b0, rd_fix = 1'b0;
    logic [11:0] src0_csum = '0, src1_csum = '0;
    logic src0_rdy, src1_rdy, fix_checksum_vld, head_src, err_underflow, err_overflow;
    logic [11:0] fix_new_checksum;
    logic [2:0] occupancy;
    int errors = 0, checks = 0;
    logic [12:0] mq[$];
    logic m_last = 1'b1, m_ovf = 1'b0, m_unf = 1'b0;

    fix_checksum_scheduler #(.DEPTH(DEPTH), .CSUM_WIDTH(12)) dut (
        .clk(clk), .reset(reset),
        .src0_vld(src0_vld), .src0_csum(src0_csum), .src0_rdy(src0_rdy),
        .src1_vld(src1_vld), .src1_csum(src1_csum), .src1_rdy(src1_rdy),
        .fix_new_checksum(fix_new_checksum), .fix_checksum_vld(fix_checksum_vld),
        .head_src(head_src), .rd_fix(rd_fix), .occupancy(occupancy),
        .err_underflow(err_underflow), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // model grant: {src1_rdy, src0_rdy}
    function automatic logic [1:0] pred_rdy();
        if (reset || mq.size() >= DEPTH) return 2'b00;
        if (src0_vld && src1_vld) return m_last ? 2'b01 : 2'b10;
        return {src1_vld, src0_vld};
    endfunction

    task automatic tick();
        logic [1:0] g;
        int n;
        g = pred_rdy();
        n = mq.size();
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_last = 1'b1;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (rd_fix && n > 0) void'(mq.pop_front());
            if (rd_fix && n == 0) m_unf = 1'b1;
            if ((src0_vld || src1_vld) && n == DEPTH) m_ovf = 1'b1;
            if (g[0]) begin mq.push_back({1'b0, src0_csum}); m_last = 1'b0; end
            if (g[1]) begin mq.push_back({1'b1, src1_csum}); m_last = 1'b1; end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        src0_vld = 1'b0;
        src1_vld = 1'b0;
        rd_fix = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        src0_vld = 1'b1;
        #1;
        checks++; if (src0_rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b exp 0", src0_rdy); end
        tick();
        tick();
        src0_vld = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if ({fix_checksum_vld, occupancy, fix_new_checksum, head_src, err_underflow, err_overflow} !== '0) begin
            errors++;
            $display("FAIL reset_state: vld=%b occ=%0d csum=%h src=%b unf=%b ovf=%b exp all 0",
                     fix_checksum_vld, occupancy, fix_new_checksum, head_src, err_underflow, err_overflow);
        end
    endtask

    task automatic test_single();
        do_reset();
        src0_vld = 1'b1;
        src0_csum = 12'h123;
        #1;
        checks++; if ({src1_rdy, src0_rdy} !== 2'b01) begin errors++; $display("FAIL single_rdy: got %b exp 01", {src1_rdy, src0_rdy}); end
        tick();
        src0_vld = 1'b0;
        #1;
        checks++;
        if (fix_checksum_vld !== 1'b1 || fix_new_checksum !== 12'h123 || head_src !== 1'b0 || occupancy !== 3'd1) begin
            errors++;
            $display("FAIL single_head: vld=%b csum=%h src=%b occ=%0d exp 1 123 0 1",
                     fix_checksum_vld, fix_new_checksum, head_src, occupancy);
        end
    endtask

    task automatic test_contention();
        do_reset();
        src0_vld = 1'b1; src0_csum = 12'h111;
        src1_vld = 1'b1; src1_csum = 12'h222;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if ({src1_rdy, src0_rdy} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++; $display("FAIL contention_grant%0d: got %b", i, {src1_rdy, src0_rdy});
            end
            tick();
        end
        #1;
        checks++;
        if ({src1_rdy, src0_rdy} !== 2'b00 || occupancy !== 3'd4) begin
            errors++; $display("FAIL contention_full: rdy=%b occ=%0d exp 00 4", {src1_rdy, src0_rdy}, occupancy);
        end
        tick();
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL contention_ovf: got %b exp 1", err_overflow); end
        src0_vld = 1'b0;
        src1_vld = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if (fix_new_checksum !== ((i % 2 == 0) ? 12'h111 : 12'h222) || head_src !== 1'(i % 2)) begin
                errors++; $display("FAIL contention_pop%0d: csum=%h src=%b", i, fix_new_checksum, head_src);
            end
            rd_fix = 1'b1;
            tick();
            rd_fix = 1'b0;
        end
        checks++; if (fix_checksum_vld !== 1'b0) begin errors++; $display("FAIL contention_empty: vld=%b exp 0", fix_checksum_vld); end
    endtask

    task automatic test_full_pop();
        do_reset();
        src0_vld = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            src0_csum = 12'(12'h300 + i);
            tick();
        end
        src0_vld = 1'b0;
        src1_vld = 1'b1;
        src1_csum = 12'h789;
        rd_fix = 1'b1;
        #1;
        checks++;
        if (src1_rdy !== 1'b0 || occupancy !== 3'd4) begin
            errors++; $display("FAIL fullpop_block: rdy=%b occ=%0d exp 0 4", src1_rdy, occupancy);
        end
        tick();
        rd_fix = 1'b0;
        #1;
        checks++;
        if (src1_rdy !== 1'b1 || occupancy !== 3'd3) begin
            errors++; $display("FAIL fullpop_grant: rdy=%b occ=%0d exp 1 3", src1_rdy, occupancy);
        end
        tick();
        src1_vld = 1'b0;
        #1;
        checks++;
        if (occupancy !== 3'd4 || err_overflow !== 1'b1) begin
            errors++; $display("FAIL fullpop_refill: occ=%0d ovf=%b exp 4 1", occupancy, err_overflow);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] ec;
        do_reset();
        src0_vld = 1'b1;
        src0_csum = 12'h010; tick();
        src0_csum = 12'h020; tick();
        src0_vld = 1'b0;
        src1_vld = 1'b1;
        src1_csum = 12'h456;
        rd_fix = 1'b1;
        tick();
        checks++; if (occupancy !== 3'd2) begin errors++; $display("FAIL wrap_pushpop: occ=%0d exp 2", occupancy); end
        for (int i = 0; i < DEPTH + 3; i++) begin
            src0_vld = (i % 2 == 0);
            src1_vld = (i % 2 == 1);
            src0_csum = 12'($urandom);
            src1_csum = 12'($urandom);
            tick();
            ec = mq[0][11:0];
            checks++;
            if (occupancy !== 3'd2 || fix_new_checksum !== ec || head_src !== mq[0][12]) begin
                errors++; $display("FAIL wrap_pair%0d: occ=%0d csum=%h src=%b exp 2 %h %b",
                                   i, occupancy, fix_new_checksum, head_src, ec, mq[0][12]);
            end
        end
        src0_vld = 1'b0;
        src1_vld = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ec = mq[0][11:0];
            checks++;
            if (fix_new_checksum !== ec || head_src !== mq[0][12]) begin
                errors++; $display("FAIL wrap_drain%0d: csum=%h src=%b exp %h %b", i, fix_new_checksum, head_src, ec, mq[0][12]);
            end
            tick();
        end
        rd_fix = 1'b0;
    endtask

    task automatic test_underflow();
        do_reset();
        rd_fix = 1'b1;
        tick();
        rd_fix = 1'b0;
        checks++;
        if (err_underflow !== 1'b1 || occupancy !== 3'd0 || fix_checksum_vld !== 1'b0) begin
            errors++; $display("FAIL underflow_flag: unf=%b occ=%0d vld=%b exp 1 0 0", err_underflow, occupancy, fix_checksum_vld);
        end
        src1_vld = 1'b1;
        src1_csum = 12'h987;
        tick();
        src1_vld = 1'b0;
        checks++;
        if (fix_new_checksum !== 12'h987 || head_src !== 1'b1 || occupancy !== 3'd1 || err_underflow !== 1'b1) begin
            errors++; $display("FAIL underflow_ptrs: csum=%h src=%b occ=%0d unf=%b exp 987 1 1 1",
                               fix_new_checksum, head_src, occupancy, err_underflow);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rd_fix = 1'b1;
        tick();
        rd_fix = 1'b0;
        src0_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src0_csum = 12'(12'h500 + i);
            tick();
        end
        reset = 1'b1;
        #1;
        checks++; if (src0_rdy !== 1'b0) begin errors++; $display("FAIL resetmid_rdy: got %b exp 0", src0_rdy); end
        tick();
        checks++;
        if (fix_checksum_vld !== 1'b0 || occupancy !== 3'd0 || err_underflow !== 1'b0 || err_overflow !== 1'b0) begin
            errors++; $display("FAIL resetmid_state: vld=%b occ=%0d unf=%b ovf=%b exp all 0",
                               fix_checksum_vld, occupancy, err_underflow, err_overflow);
        end
        reset = 1'b0;
        src1_vld = 1'b1;
        #1;
        checks++; if ({src1_rdy, src0_rdy} !== 2'b01) begin errors++; $display("FAIL resetmid_grant: got %b exp 01", {src1_rdy, src0_rdy}); end
        src0_vld = 1'b0;
        src1_vld = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] exp;
        logic [11:0] ec;
        logic es;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!src0_vld) begin src0_vld = 1'($urandom_range(0, 1)); src0_csum = 12'($urandom); end
            if (!src1_vld) begin src1_vld = 1'($urandom_range(0, 1)); src1_csum = 12'($urandom); end
            rd_fix = ($urandom_range(0, 9) < 4);
            #1;
            exp = pred_rdy();
            ec = mq.size() != 0 ? mq[0][11:0] : 12'h000;
            es = mq.size() != 0 ? mq[0][12] : 1'b0;
            checks++;
            if ({src1_rdy, src0_rdy} !== exp) begin
                errors++; $display("FAIL random_rdy%0d: got %b exp %b", i, {src1_rdy, src0_rdy}, exp);
            end
            checks++;
            if (fix_checksum_vld !== (mq.size() != 0) || fix_new_checksum !== ec || head_src !== es ||
                occupancy !== 3'(mq.size()) || err_overflow !== m_ovf || err_underflow !== m_unf) begin
                errors++; $display("FAIL random_head%0d: vld=%b csum=%h src=%b occ=%0d ovf=%b unf=%b exp csum=%h src=%b occ=%0d ovf=%b unf=%b",
                                   i, fix_checksum_vld, fix_new_checksum, head_src, occupancy, err_overflow, err_underflow,
                                   ec, es, mq.size(), m_ovf, m_unf);
            end
            tick();
            if (exp[0]) src0_vld = 1'b0;
            if (exp[1]) src1_vld = 1'b0;
        end
        rd_fix = 1'b0;
        src0_vld = 1'b0;
        src1_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_full_pop();
        test_wrap();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
